// File: rtl/dual_port_mem_ctrl.sv
// Shared-array dual-port memory controller: two req/ready ports, selectable read latency,
// same-address collision policy with saturating counter, optional fill engine (MEM_INIT_EN).
//   state  | meaning
//   S_RST  | held in reset, both ports not ready
//   S_FILL | writing INIT_VALUE to every address (MEM_INIT_EN builds only)
//   S_RUN  | both ports ready, no backpressure
module dual_port_mem_ctrl #(
    parameter int                 ADDR_W     = 18,
    parameter int                 DATA_W     = 8,
    parameter int                 RD_LAT     = 1,
    parameter int                 RDW_MODE   = 0,
    parameter int                 CNT_W      = 16,
    parameter logic [DATA_W-1:0]  INIT_VALUE = 8'hFF
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic              a_ready_o,
    output logic              a_rvalid_o,
    output logic [DATA_W-1:0] a_rdata_o,
    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              b_ready_o,
    output logic              b_rvalid_o,
    output logic [DATA_W-1:0] b_rdata_o,
    output logic              busy_o,
    output logic              collision_o,
    output logic [CNT_W-1:0]  coll_count_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready_q;
    logic              a_acc, b_acc, a_wr, b_wr, a_rd, b_rd;
    logic              same_addr, coll_hit;
    logic              fill_act;
    logic [ADDR_W-1:0] fill_addr;
    logic              wa_en, wb_en;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_data;
    logic [DATA_W-1:0] a_word, b_word;
    logic              a_rvalid_q, b_rvalid_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
    logic              coll_q;
    logic [CNT_W-1:0]  coll_count_q, coll_count_d;

`ifdef MEM_INIT_EN
    typedef enum logic [1:0] {S_RST, S_FILL, S_RUN} state_t;
    logic              busy_q;
    logic [ADDR_W-1:0] fill_addr_q;
`else
    typedef enum logic {S_RST, S_RUN} state_t;
`endif
    state_t state_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_RST;
            ready_q <= 1'b0;
`ifdef MEM_INIT_EN
            busy_q      <= 1'b0;
            fill_addr_q <= '0;
`endif
        end else begin
            case (state_q)
                S_RST: begin
`ifdef MEM_INIT_EN
                    state_q     <= S_FILL;
                    busy_q      <= 1'b1;
                    fill_addr_q <= '0;
`else
                    state_q <= S_RUN;
                    ready_q <= 1'b1;
`endif
                end
`ifdef MEM_INIT_EN
                S_FILL: begin
                    if (fill_addr_q == {ADDR_W{1'b1}}) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        fill_addr_q <= fill_addr_q + ADDR_W'(1);
                    end
                end
`endif
                S_RUN:   ready_q <= 1'b1;
                default: state_q <= S_RST;
            endcase
        end
    end

`ifdef MEM_INIT_EN
    assign fill_act  = busy_q;
    assign fill_addr = fill_addr_q;
    assign busy_o    = busy_q;
`else
    assign fill_act  = 1'b0;
    assign fill_addr = '0;
    assign busy_o    = 1'b0;
`endif

    assign a_acc     = a_req_i & ready_q;
    assign b_acc     = b_req_i & ready_q;
    assign a_wr      = a_acc & a_we_i;
    assign b_wr      = b_acc & b_we_i;
    assign a_rd      = a_acc & ~a_we_i;
    assign b_rd      = b_acc & ~b_we_i;
    assign same_addr = (a_addr_i == b_addr_i);
    assign coll_hit  = a_acc & b_acc & same_addr & (a_we_i | b_we_i);

    // Fill borrows the port-A write path; on a W/W collision port A wins.
    assign wa_en   = fill_act | a_wr;
    assign wa_addr = fill_act ? fill_addr : a_addr_i;
    assign wa_data = fill_act ? INIT_VALUE : a_wdata_i;
    assign wb_en   = b_wr & ~(a_wr & same_addr);

    always_ff @(posedge clock_i) begin
        if (wa_en) mem[wa_addr] <= wa_data;
        if (wb_en) mem[b_addr_i] <= b_wdata_i;
    end

    assign a_word = ((RDW_MODE != 0) && b_wr && same_addr) ? b_wdata_i : mem[a_addr_i];
    assign b_word = ((RDW_MODE != 0) && a_wr && same_addr) ? a_wdata_i : mem[b_addr_i];

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              a_v1_q, b_v1_q;
            logic [DATA_W-1:0] a_d1_q, b_d1_q;

            always_ff @(posedge clock_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    a_v1_q     <= 1'b0;
                    b_v1_q     <= 1'b0;
                    a_d1_q     <= '0;
                    b_d1_q     <= '0;
                    a_rvalid_q <= 1'b0;
                    b_rvalid_q <= 1'b0;
                    a_rdata_q  <= '0;
                    b_rdata_q  <= '0;
                end else begin
                    a_v1_q     <= a_rd;
                    b_v1_q     <= b_rd;
                    if (a_rd) a_d1_q <= a_word;
                    if (b_rd) b_d1_q <= b_word;
                    a_rvalid_q <= a_v1_q;
                    b_rvalid_q <= b_v1_q;
                    if (a_v1_q) a_rdata_q <= a_d1_q;
                    if (b_v1_q) b_rdata_q <= b_d1_q;
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clock_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    a_rvalid_q <= 1'b0;
                    b_rvalid_q <= 1'b0;
                    a_rdata_q  <= '0;
                    b_rdata_q  <= '0;
                end else begin
                    a_rvalid_q <= a_rd;
                    b_rvalid_q <= b_rd;
                    if (a_rd) a_rdata_q <= a_word;
                    if (b_rd) b_rdata_q <= b_word;
                end
            end
        end
    endgenerate

    assign coll_count_d = (coll_hit && (coll_count_q != {CNT_W{1'b1}}))
                          ? coll_count_q + CNT_W'(1) : coll_count_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            coll_q       <= 1'b0;
            coll_count_q <= '0;
        end else begin
            coll_q       <= coll_hit;
            coll_count_q <= coll_count_d;
        end
    end

    assign a_ready_o    = ready_q;
    assign b_ready_o    = ready_q;
    assign a_rvalid_o   = a_rvalid_q;
    assign b_rvalid_o   = b_rvalid_q;
    assign a_rdata_o    = a_rdata_q;
    assign b_rdata_o    = b_rdata_q;
    assign collision_o  = coll_q;
    assign coll_count_o = coll_count_q;

endmodule

// File: tb/tb_dual_port_mem_ctrl.sv
// Bench for dual_port_mem_ctrl: two instances (RD_LAT=1/old-data/CNT_W=2 and
// RD_LAT=2/new-data/CNT_W=16) driven in lockstep against a transaction-level model.
module tb_dual_port_mem_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ready [2];
    logic          b_ready [2];
    logic          a_rvalid [2];
    logic          b_rvalid [2];
    logic          busy [2];
    logic          coll [2];
    logic [DW-1:0] a_rdata [2];
    logic [DW-1:0] b_rdata [2];
    logic [1:0]    cc0;
    logic [15:0]   cc1;

    dual_port_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .RDW_MODE(0), .CNT_W(2),
                         .INIT_VALUE(8'hFF)) dut0 (
        .clock_i(clk), .reset_n_i(rst_n),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_ready_o(a_ready[0]), .a_rvalid_o(a_rvalid[0]), .a_rdata_o(a_rdata[0]),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_ready_o(b_ready[0]), .b_rvalid_o(b_rvalid[0]), .b_rdata_o(b_rdata[0]),
        .busy_o(busy[0]), .collision_o(coll[0]), .coll_count_o(cc0));

    dual_port_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .RDW_MODE(1), .CNT_W(16),
                         .INIT_VALUE(8'hFF)) dut1 (
        .clock_i(clk), .reset_n_i(rst_n),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_ready_o(a_ready[1]), .a_rvalid_o(a_rvalid[1]), .a_rdata_o(a_rdata[1]),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_ready_o(b_ready[1]), .b_rvalid_o(b_rvalid[1]), .b_rdata_o(b_rdata[1]),
        .busy_o(busy[1]), .collision_o(coll[1]), .coll_count_o(cc1));

    typedef struct {
        int due;
        logic [DW-1:0] d;
    } rd_t;

    typedef struct {
        int ar, aw, aa, ad;
        int br, bw, ba, bd;
        int ec;
        int ea0, eb0, ea1, eb1;
    } vec_t;

    // Model state; queue index = instance*2 + port (0 = A, 1 = B).
    logic [DW-1:0] mm [DEPTH];
    rd_t           rq [4][$];
    logic [DW-1:0] held [4];
    bit            exp_rv [4];
    int            cnt [2];
    int            cmax [2] = '{3, 65535};
    bit            coll_m;
    int            since;
    int            ecount;
    int            checks = 0;
    int            errors = 0;
    vec_t          tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit ready_m();
`ifdef MEM_INIT_EN
        return since >= DEPTH + 1;
`else
        return since >= 1;
`endif
    endfunction

    function automatic bit busy_m();
`ifdef MEM_INIT_EN
        return (since >= 1) && (since <= DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input int ar, input int aw, input int aa, input int ad,
                         input int br, input int bw, input int ba, input int bd);
        a_req = 1'(ar); a_we = 1'(aw); a_addr = AW'(aa); a_wdata = DW'(ad);
        b_req = 1'(br); b_we = 1'(bw); b_addr = AW'(ba); b_wdata = DW'(bd);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("a_ready%0d", k), 32'(a_ready[k]), 32'(ready_m()));
            chk($sformatf("b_ready%0d", k), 32'(b_ready[k]), 32'(ready_m()));
            chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(busy_m()));
            chk($sformatf("collision%0d", k), 32'(coll[k]), 32'(coll_m));
            chk($sformatf("a_rvalid%0d", k), 32'(a_rvalid[k]), 32'(exp_rv[k*2]));
            chk($sformatf("a_rdata%0d", k), 32'(a_rdata[k]), 32'(held[k*2]));
            chk($sformatf("b_rvalid%0d", k), 32'(b_rvalid[k]), 32'(exp_rv[k*2+1]));
            chk($sformatf("b_rdata%0d", k), 32'(b_rdata[k]), 32'(held[k*2+1]));
        end
        chk("coll_count0", 32'(cc0), 32'(cnt[0]));
        chk("coll_count1", 32'(cc1), 32'(cnt[1]));
    endtask

    // One clock: the model applies the transaction at the edge, then outputs are compared.
    task automatic tick();
        bit rdy, acc_a, acc_b, hit, awr, bwr;
        logic [DW-1:0] d;
        rdy   = ready_m();
        acc_a = a_req && rdy;
        acc_b = b_req && rdy;
        awr   = acc_a && a_we;
        bwr   = acc_b && b_we;
        @(posedge clk);
        ecount++;
        hit    = acc_a && acc_b && (a_addr == b_addr) && (a_we || b_we);
        coll_m = hit;
        for (int k = 0; k < 2; k++) begin
            if (hit && cnt[k] < cmax[k]) cnt[k]++;
            if (acc_a && !a_we) begin
                d = (k == 1 && bwr && b_addr == a_addr) ? b_wdata : mm[a_addr];
                rq[k*2].push_back('{ecount + k, d});
            end
            if (acc_b && !b_we) begin
                d = (k == 1 && awr && a_addr == b_addr) ? a_wdata : mm[b_addr];
                rq[k*2+1].push_back('{ecount + k, d});
            end
        end
        if (awr) mm[a_addr] = a_wdata;
        if (bwr && !(awr && a_addr == b_addr)) mm[b_addr] = b_wdata;
        since++;
`ifdef MEM_INIT_EN
        if (since == DEPTH + 1)
            for (int i = 0; i < DEPTH; i++) mm[i] = 8'hFF;
`endif
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_rv[i] = 1'b0;
            if (rq[i].size() > 0 && rq[i][0].due == ecount) begin
                exp_rv[i] = 1'b1;
                held[i]   = rq[i][0].d;
                void'(rq[i].pop_front());
            end
        end
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        #1;
        for (int i = 0; i < 4; i++) begin
            rq[i].delete();
            held[i]   = '0;
            exp_rv[i] = 1'b0;
        end
        cnt[0] = 0;
        cnt[1] = 0;
        coll_m = 1'b0;
        since  = 0;
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();
    endtask

    // Requests issued before ready must be ignored; writes only, so nothing reads undefined words.
    task automatic wait_ready();
        bit ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            drive(1, 1, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                  1, 1, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
            tick();
            if (a_ready[0]) ok = 1'b1;
        end
        idle();
        chk("wait_ready_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp3;
        int            nb;
        int            sat_exp [5] = '{1, 2, 3, 3, 3};

        tbl[0]  = '{1, 1, 3, 'h5A, 0, 0, 0, 0,    0, 0,    0,    0,    0};
        tbl[1]  = '{0, 0, 0, 0,    1, 0, 3, 0,    0, 0,    'h5A, 0,    'h5A};
        tbl[2]  = '{1, 1, 7, 'h11, 1, 1, 7, 'h22, 1, 0,    0,    0,    0};
        tbl[3]  = '{1, 0, 7, 0,    0, 0, 0, 0,    0, 'h11, 0,    'h11, 0};
        tbl[4]  = '{1, 1, 9, 'h33, 1, 0, 9, 0,    1, 0,    'hFF, 0,    'h33};
        tbl[5]  = '{1, 0, 9, 0,    1, 0, 9, 0,    0, 'h33, 'h33, 'h33, 'h33};
        tbl[6]  = '{1, 0, 0, 0,    1, 0, 15, 0,   0, 'hFF, 'hFF, 'hFF, 'hFF};
        tbl[7]  = '{1, 0, 5, 0,    1, 1, 5, 'h44, 1, 'hFF, 0,    'h44, 0};
        tbl[8]  = '{1, 0, 5, 0,    1, 1, 5, 'h55, 1, 'h44, 0,    'h55, 0};
        tbl[9]  = '{1, 1, 1, 'h01, 1, 1, 2, 'h02, 0, 0,    0,    0,    0};
        tbl[10] = '{1, 0, 1, 0,    1, 0, 2, 0,    0, 'h01, 'h02, 'h01, 'h02};

        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        ecount = 0;
        idle();
        do_reset();

`ifdef MEM_INIT_EN
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy[0]) nb++;
        end
        chk("fill_busy_cycles", 32'(nb), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, i, 0, 0, 0, 0, 0);
            tick();
            chk("fill_readback", 32'({a_rvalid[0], a_rdata[0]}), 32'({1'b1, 8'hFF}));
        end
        idle();
        tick();
`endif
        wait_ready();

        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 1, i, 'hFF, 0, 0, 0, 0);
            tick();
        end
        idle();
        tick();

        for (int r = 0; r < 11; r++) begin
            drive(tbl[r].ar, tbl[r].aw, tbl[r].aa, tbl[r].ad,
                  tbl[r].br, tbl[r].bw, tbl[r].ba, tbl[r].bd);
            tick();
            chk($sformatf("tbl%0d_coll0", r), 32'(coll[0]), 32'(tbl[r].ec));
            chk($sformatf("tbl%0d_coll1", r), 32'(coll[1]), 32'(tbl[r].ec));
            if (tbl[r].ar != 0 && tbl[r].aw == 0)
                chk($sformatf("tbl%0d_a_rd0", r), 32'({a_rvalid[0], a_rdata[0]}),
                    32'({1'b1, 8'(tbl[r].ea0)}));
            if (tbl[r].br != 0 && tbl[r].bw == 0)
                chk($sformatf("tbl%0d_b_rd0", r), 32'({b_rvalid[0], b_rdata[0]}),
                    32'({1'b1, 8'(tbl[r].eb0)}));
            idle();
            tick();
            if (tbl[r].ar != 0 && tbl[r].aw == 0)
                chk($sformatf("tbl%0d_a_rd1", r), 32'({a_rvalid[1], a_rdata[1]}),
                    32'({1'b1, 8'(tbl[r].ea1)}));
            if (tbl[r].br != 0 && tbl[r].bw == 0)
                chk($sformatf("tbl%0d_b_rd1", r), 32'({b_rvalid[1], b_rdata[1]}),
                    32'({1'b1, 8'(tbl[r].eb1)}));
            tick();
        end

        // Reset one cycle after a read is accepted: the RD_LAT=2 result must never appear.
        drive(1, 0, 3, 0, 1, 0, 3, 0);
        tick();
        do_reset();
        chk("rst_flush_a_rvalid1", 32'(a_rvalid[1]), 32'd0);
        chk("rst_flush_b_rvalid1", 32'(b_rvalid[1]), 32'd0);
        wait_ready();
        repeat (3) tick();
`ifdef MEM_INIT_EN
        exp3 = 8'hFF;
`else
        exp3 = 8'h5A;
`endif
        drive(1, 0, 3, 0, 0, 0, 0, 0);
        tick();
        chk("post_rst_addr3", 32'({a_rvalid[0], a_rdata[0]}), 32'({1'b1, exp3}));
        idle();
        repeat (2) tick();

        do_reset();
        wait_ready();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 6, 'h10 + i, 1, 1, 6, 'hE0 + i);
            tick();
            chk($sformatf("sat_cnt0_%0d", i), 32'(cc0), 32'(sat_exp[i]));
            chk($sformatf("sat_cnt1_%0d", i), 32'(cc1), 32'(i + 1));
        end
        drive(1, 0, 6, 0, 0, 0, 0, 0);
        tick();
        chk("ww_a_wins", 32'({a_rvalid[0], a_rdata[0]}), 32'({1'b1, 8'h14}));
        idle();
        repeat (2) tick();

        for (int n = 0; n < 400; n++) begin
            int aa, ba;
            aa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
            ba = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
            drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), aa, int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), ba, int'($urandom_range(0, 255)));
            tick();
        end
        idle();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
